// File: rtl/cpu6_pipereg_hs_pkg.sv
// Shared constants for the CPU6 handshaked pipeline-stage register.
//
// Holds the FSM state encoding and the default CPU6 bundle widths so that
// every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) decodes the same way.
// Contents:
//   CPU6_XLEN            - architectural register width
//   CPU6_PIPEREG_DATA_W  - default data bundle width (instr + pc)
//   CPU6_PIPEREG_ST_*    - state width and state encodings
package cpu6_pipereg_hs_pkg;

  localparam int unsigned CPU6_XLEN           = 32;
  localparam int unsigned CPU6_PIPEREG_DATA_W = 2 * CPU6_XLEN;

  localparam int unsigned CPU6_PIPEREG_ST_W = 2;

  typedef logic [CPU6_PIPEREG_ST_W-1:0] cpu6_pipereg_st_t;

  localparam cpu6_pipereg_st_t CPU6_PIPEREG_ST_EMPTY = 2'd0;  // main invalid
  localparam cpu6_pipereg_st_t CPU6_PIPEREG_ST_FULL  = 2'd1;  // main valid, skid empty
  localparam cpu6_pipereg_st_t CPU6_PIPEREG_ST_SKID  = 2'd2;  // main and skid valid

endpackage

// File: rtl/cpu6_satcnt.sv
// Parametrised-width saturating up-counter.
//
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset, clears the count
//   inc   - increment request for this cycle
//   cnt   - current count; sticks at all-ones once reached
module cpu6_satcnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cpu6_pipereg_hs.sv
// Handshaked pipeline-stage register with a 2-entry skid buffer and flush.
//
// The main register drives the outputs directly; the skid register catches
// the entry accepted in the cycle downstream stalls, so in_ready can be a
// flop and throughput stays at one entry per cycle. Flush empties the stage
// and drives the bubble control value.
//
// Ports:
//   clk, reset          - clock (rising edge), async active-low reset
//   flush               - synchronous kill of held and incoming entries
//   in_valid/in_ready   - upstream handshake (in_ready is registered)
//   in_ctrl/in_data     - upstream control and data bundles
//   out_valid/out_ready - downstream handshake
//   out_ctrl/out_data   - held control (CTRL_BUBBLE when empty) and data
//
// Optional build macro CPU6_PIPEREG_PERF_EN adds perf_stall_cnt and
// perf_flush_cnt saturating 32-bit counters.
module cpu6_pipereg_hs
  import cpu6_pipereg_hs_pkg::*;
#(
  parameter int unsigned        CTRL_W      = 16,
  parameter int unsigned        DATA_W      = CPU6_PIPEREG_DATA_W,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef CPU6_PIPEREG_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  cpu6_pipereg_st_t  state_q, state_d;
  logic              in_ready_q;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != CPU6_PIPEREG_ST_EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // Data is left alone so out_data keeps its last value.
      state_d     = CPU6_PIPEREG_ST_EMPTY;
      main_ctrl_d = CTRL_BUBBLE;
    end else begin
      case (state_q)
        CPU6_PIPEREG_ST_EMPTY: begin
          if (in_fire) begin
            state_d     = CPU6_PIPEREG_ST_FULL;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        CPU6_PIPEREG_ST_FULL: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            state_d     = CPU6_PIPEREG_ST_SKID;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_fire) begin
            // Keep main_ctrl at the bubble value whenever empty so out_ctrl
            // is a plain flop output.
            state_d     = CPU6_PIPEREG_ST_EMPTY;
            main_ctrl_d = CTRL_BUBBLE;
          end
        end
        CPU6_PIPEREG_ST_SKID: begin
          if (out_fire) begin
            state_d     = CPU6_PIPEREG_ST_FULL;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: begin
          state_d     = CPU6_PIPEREG_ST_EMPTY;
          main_ctrl_d = CTRL_BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CPU6_PIPEREG_ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= CTRL_BUBBLE;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != CPU6_PIPEREG_ST_SKID);
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready = in_ready_q;
  assign out_ctrl = main_ctrl_q;
  assign out_data = main_data_q;

`ifdef CPU6_PIPEREG_PERF_EN
  cpu6_satcnt #(
    .W (32)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .cnt   (perf_stall_cnt)
  );

  cpu6_satcnt #(
    .W (32)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush & out_valid),
    .cnt   (perf_flush_cnt)
  );
`endif

`ifndef SYNTHESIS
  // Upstream must hold a stalled offer; a flush releases that obligation.
  a_in_stable: assert property (@(posedge clk) disable iff (!reset)
    (in_valid && !in_ready_q && !flush) |=>
      (in_valid && $stable(in_ctrl) && $stable(in_data)));
`endif

endmodule

// File: tb/tb_cpu6_pipereg_hs.sv
// Directed self-checking bench for cpu6_pipereg_hs (default parameters).
// Define CPU6_PIPEREG_PERF_EN on both bench and RTL to cover the counters.
module tb_cpu6_pipereg_hs;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_ctrl;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ctrl;
  logic [63:0] out_data;
`ifdef CPU6_PIPEREG_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int n_vec;
  int n_miss;

  cpu6_pipereg_hs dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef CPU6_PIPEREG_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = d[15:0];
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 64'h0);

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_ctrl", 64'(out_ctrl), 64'h0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);

    // Streaming with out_ready held high: one-cycle latency, no stalls.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i));
      step();
      check("stream_data", out_data, 64'(i));
      check("stream_ctrl", 64'(out_ctrl), 64'(i));
      check("stream_valid", 64'(out_valid), 64'h1);
      check("stream_in_ready", 64'(in_ready), 64'h1);
    end
    drive(1'b0, 64'h0);
    step();
    check("drain_valid", 64'(out_valid), 64'h0);
    check("drain_bubble", 64'(out_ctrl), 64'h0);
    check("drain_hold_data", out_data, 64'h8);

    // Backpressure: A,B,C back-to-back with downstream stalled.
    out_ready = 1'b0;
    drive(1'b1, 64'hA);
    step();
    check("bp_a_out", out_data, 64'hA);
    check("bp_a_in_ready", 64'(in_ready), 64'h1);
    drive(1'b1, 64'hB);
    step();
    check("bp_skid_in_ready", 64'(in_ready), 64'h0);
    check("bp_skid_out", out_data, 64'hA);
    drive(1'b1, 64'hC);
    step();
    check("bp_hold_out", out_data, 64'hA);
    check("bp_hold_in_ready", 64'(in_ready), 64'h0);
    check("bp_hold_valid", 64'(out_valid), 64'h1);
    out_ready = 1'b1;
    step();
    check("bp_b_out", out_data, 64'hB);
    check("bp_b_ctrl", 64'(out_ctrl), 64'hB);
    check("bp_b_in_ready", 64'(in_ready), 64'h1);
    step();
    check("bp_c_out", out_data, 64'hC);
    drive(1'b0, 64'h0);
    step();
    check("bp_empty", 64'(out_valid), 64'h0);

    // Flush while in SKID with D offered.
    out_ready = 1'b0;
    drive(1'b1, 64'h11);
    step();
    drive(1'b1, 64'h22);
    step();
    check("fl_pre_in_ready", 64'(in_ready), 64'h0);
    drive(1'b1, 64'hDD);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 64'h0);
    check("fl_valid", 64'(out_valid), 64'h0);
    check("fl_bubble", 64'(out_ctrl), 64'h0);
    check("fl_in_ready", 64'(in_ready), 64'h1);
    check("fl_hold_data", out_data, 64'h11);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_no_d", 64'(out_valid), 64'h0);
    end

    // Asynchronous reset between edges with the stage in SKID.
    out_ready = 1'b0;
    drive(1'b1, 64'h33);
    step();
    drive(1'b1, 64'h44);
    step();
    drive(1'b0, 64'h0);
    check("ar_pre_valid", 64'(out_valid), 64'h1);
    #1 reset = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid), 64'h0);
    check("ar_in_ready", 64'(in_ready), 64'h1);
    check("ar_ctrl", 64'(out_ctrl), 64'h0);
    check("ar_data", out_data, 64'h0);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 64'hEE);
    step();
    check("ar_e_data", out_data, 64'hEE);
    check("ar_e_valid", 64'(out_valid), 64'h1);
    drive(1'b0, 64'h0);
    step();
    check("ar_e_drain", 64'(out_valid), 64'h0);

`ifdef CPU6_PIPEREG_PERF_EN
    // Counter check from a clean reset.
    reset = 1'b0;
    #2 reset = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 64'h55);
    step();
    drive(1'b0, 64'h0);
    repeat (5) step();
    check("perf_stall5", 64'(perf_stall_cnt), 64'd5);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    check("perf_flush1", 64'(perf_flush_cnt), 64'd1);
    check("perf_stall_after_fl", 64'(perf_stall_cnt), 64'd5);
    force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.u_stall_cnt.cnt_q;
    out_ready = 1'b0;
    drive(1'b1, 64'h66);
    step();
    drive(1'b0, 64'h0);
    repeat (2) step();
    check("perf_sat", 64'(perf_stall_cnt), 64'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cpu6_pipereg_hs.md
Name: cpu6_pipereg_hs

Overview:
- Parametrised, handshaked pipeline-stage register replacing the fixed-width, always-advancing inter-stage registers between controller and datapath.
- Carries a control bundle and a data bundle (instr, pc, operands) with valid/ready flow control, a 2-entry skid buffer for full throughput under backpressure, and synchronous flush that inserts a bubble.
- Instantiated per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), with widths set by parameters.

Parameters:
- CTRL_W, 16, width of control bundle (memwrite, memtoreg, branchtype, alusrc, regwrite, jump, alucontrol, immtype, ...).
- DATA_W, 64, width of data bundle (default: instr + pc at CPU6_XLEN=32).
- CTRL_BUBBLE, {CTRL_W{1'b0}}, control value presented on out_ctrl when empty or flushed; all-zero means no regwrite and no memwrite.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (reset==0 resets)
- flush  in  1  synchronous kill of all held and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control bundle; CTRL_BUBBLE when out_valid=0
- out_data  out  DATA_W  data bundle; holds last value when out_valid=0

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Payload transfers only on fire. in_valid/in_ctrl/in_data must stay stable until fire (upstream obligation; checked by assertion).
- Storage: main register (drives outputs directly) and skid register. Outputs come only from flops, with no combinational path from in_* to out_*.
- FSM states: EMPTY (main invalid), FULL (main valid, skid empty), SKID (both valid).
- EMPTY:
  - in_fire -> FULL, main <= input.
  - Otherwise stay EMPTY.
- FULL:
  - in_fire & out_fire -> FULL, main <= input.
  - in_fire & !out_fire -> SKID, skid <= input.
  - !in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- SKID:
  - in_ready=0.
  - out_fire -> FULL, main <= skid.
  - Otherwise hold.
- in_ready = (state != SKID), registered as the next-state decode.
- out_valid = (state != EMPTY). out_ctrl = main_ctrl when valid, else CTRL_BUBBLE.
- Latency: 1 cycle in to out when downstream ready. Throughput: 1 entry/cycle sustained. Order is strictly FIFO and no entry is ever duplicated or dropped except by flush.
- Flush has highest priority:
  - Next state EMPTY and main_ctrl <= CTRL_BUBBLE.
  - An entry accepted on the flush cycle (in_fire) is discarded.
  - out_fire on the flush cycle is still counted as transferred by downstream.
  - in_ready = 1 in the cycle after flush.
- Reset (reset==0, asynchronous):
  - State EMPTY, out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, skid cleared, in_ready=1.
  - Reset mid-transfer discards all entries. The first fire is permitted on the first rising edge with reset==1.
- out_ready=1 held constantly makes the block equivalent to a plain enable-free pipeline register with bubble-on-empty.

Optional Feature:
- Macro CPU6_PIPEREG_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments each cycle out_valid & !out_ready.
  - perf_flush_cnt increments each cycle flush & out_valid.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and logic absent, with identical datapath behaviour.

Decomposition:
- defines.v (shared): CPU6_PIPEREG_ST_W=2, CPU6_PIPEREG_ST_EMPTY=2'd0, CPU6_PIPEREG_ST_FULL=2'd1, CPU6_PIPEREG_ST_SKID=2'd2; CPU6 bundle widths stay there too.
- Sub-module: cpu6_satcnt (parametrised-width saturating counter), used twice under CPU6_PIPEREG_PERF_EN. The FSM and registers stay in cpu6_pipereg_hs.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
- Streaming: out_ready=1, push data 1..8 on consecutive cycles -> out_data 1..8 on cycles 1..8 after each push, in_ready never drops.
- Backpressure: push A,B,C back-to-back; out_ready=0 from cycle 1 -> state SKID holding A (out) and B; in_ready=0; C held upstream. Release out_ready -> outputs A,B,C in order, none lost.
- Flush in SKID with in_valid=1 (D): -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, in_ready=1; D never appears on out.
- Async reset mid-stream: drop reset between clock edges with state SKID -> out_valid=0 immediately (before next edge); after release, push E -> out_data=E after 1 cycle.
- CPU6_PIPEREG_PERF_EN: out_valid held with out_ready=0 for 5 cycles, then one flush -> perf_stall_cnt=5, perf_flush_cnt=1; force counter to 32'hFFFF_FFFF and stall -> stays saturated.
